// File: rtl/sonar_ping_sequencer_if.sv
// Sample-stream, RAM-write, transducer-drive and echo-report signals of the sonar ping sequencer.
// The slave modport is the sequencer's view; the master modport is the view of the logic around it.
interface sonar_ping_sequencer_if #(
  parameter int ADDR_W = 11
);
  logic              frame_start;
  logic              sample_valid;
  logic [7:0]        sample;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              pulse_p;
  logic              pulse_n;
  logic              echo_valid;
  logic [ADDR_W-1:0] echo_addr;
  logic              busy;

  modport slave (
    input  frame_start, sample_valid, sample,
    output wr_en, wr_bank, wr_addr, wr_data, pulse_p, pulse_n, echo_valid, echo_addr, busy
  );

  modport master (
    output frame_start, sample_valid, sample,
    input  wr_en, wr_bank, wr_addr, wr_data, pulse_p, pulse_n, echo_valid, echo_addr, busy
  );
endinterface

// File: rtl/sonar_ping_sequencer.sv
// Per-frame ping sequencer: bank flip, complementary transmit burst, sample capture into RAM.
// Optional first-echo capture is built only when SONAR_ECHO_DETECT_EN is defined.
module sonar_ping_sequencer #(
  parameter int ADDR_W           = 11,
  parameter int HALF_PERIOD      = 16,
  parameter int BURST_HALFCYCLES = 16,
  parameter int BLANK_SAMPLES    = 400,
  parameter int THRESHOLD        = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  sonar_ping_sequencer_if.slave bus
);
  localparam int PW = $clog2(HALF_PERIOD + 1);
  localparam int HW = $clog2(BURST_HALFCYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
  localparam logic [PW-1:0]     PERIOD_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [HW-1:0]     HALF_LAST   = HW'(BURST_HALFCYCLES - 1);

  // Elaboration-time guard against parameter sets the counters cannot represent.
  if (HALF_PERIOD < 1 || BURST_HALFCYCLES < 1 || THRESHOLD < 0 || THRESHOLD > 255 ||
      BLANK_SAMPLES < 0 || ADDR_W < 1 || ADDR_W > 30) begin : g_bad_cfg
    $error("sonar_ping_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, BURST, LISTEN, DONE} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [PW-1:0]     period_reg;
  logic [HW-1:0]     half_reg;
  logic              take;

  assign take = bus.sample_valid && (state_reg == BURST || state_reg == LISTEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      period_reg  <= '0;
      half_reg    <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_bank <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.pulse_p <= 1'b0;
      bus.pulse_n <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      if (bus.frame_start) begin
        state_reg   <= BURST;
        bus.wr_bank <= ~bus.wr_bank;
        addr_reg    <= '0;
        period_reg  <= '0;
        half_reg    <= '0;
        bus.pulse_p <= 1'b1;
        bus.pulse_n <= 1'b0;
        bus.busy    <= 1'b1;
      end else if (take) begin
        bus.wr_en   <= 1'b1;
        bus.wr_addr <= addr_reg;
        bus.wr_data <= bus.sample;
        if (addr_reg == LAST_ADDR) begin
          // Frame full: stop here rather than wrap into the start of the bank.
          state_reg   <= DONE;
          bus.pulse_p <= 1'b0;
          bus.pulse_n <= 1'b0;
          bus.busy    <= 1'b0;
        end else begin
          addr_reg <= addr_reg + 1'b1;
          if (state_reg == BURST) begin
            if (period_reg == PERIOD_LAST) begin
              period_reg <= '0;
              if (half_reg == HALF_LAST) begin
                state_reg   <= LISTEN;
                bus.pulse_p <= 1'b0;
                bus.pulse_n <= 1'b0;
              end else begin
                half_reg    <= half_reg + 1'b1;
                bus.pulse_p <= ~bus.pulse_p;
                bus.pulse_n <= ~bus.pulse_n;
              end
            end else begin
              period_reg <= period_reg + 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef SONAR_ECHO_DETECT_EN
  localparam logic [7:0]  THRESH = 8'(THRESHOLD);
  localparam logic [31:0] BLANK  = 32'(BLANK_SAMPLES);

  logic [7:0] prev_reg;
  logic       hit;

  // Rising crossing of the threshold, past the blanking zone that hides transmit ringing.
  assign hit = (state_reg == LISTEN) && !bus.echo_valid &&
               ({{(32-ADDR_W){1'b0}}, addr_reg} > BLANK) &&
               (prev_reg < THRESH) && (bus.sample >= THRESH);

  always_ff @(posedge clk) begin
    if (reset || bus.frame_start) begin
      prev_reg       <= '0;
      bus.echo_valid <= 1'b0;
      bus.echo_addr  <= '0;
    end else if (take) begin
      prev_reg <= bus.sample;
      if (hit) begin
        bus.echo_valid <= 1'b1;
        bus.echo_addr  <= addr_reg;
      end
    end
  end
`else
  assign bus.echo_valid = 1'b0;
  assign bus.echo_addr  = '0;
`endif
endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Randomized and directed stimulus for sonar_ping_sequencer, checked against a per-frame
// strobe-index model of the RAM writes, burst drive, busy and echo capture.
module tb_sonar_ping_sequencer;
  localparam int ADDR_W = 11;
  localparam int HP     = 16;
  localparam int BH     = 16;
  localparam int BLANK  = 400;
  localparam int TH     = 128;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sonar_ping_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  sonar_ping_sequencer #(
    .ADDR_W(ADDR_W), .HALF_PERIOD(HP), .BURST_HALFCYCLES(BH),
    .BLANK_SAMPLES(BLANK), .THRESHOLD(TH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is described by how many strobes it has accepted so far.
  bit m_bank, m_active, m_echo_v;
  int m_k, m_prev, m_echo_a;
  bit exp_wr_en, exp_p, exp_n, exp_busy;
  int exp_addr, exp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Positive-leg level once n strobes of the frame have been taken.
  function automatic bit leg_p(input int n);
    if (n >= HP * BH) return 1'b0;
    return ((n / HP) % 2) == 0;
  endfunction

  task automatic step(input bit r, input bit fs, input bit sv, input logic [7:0] s);
    reset            = r;
    bus.frame_start  = fs;
    bus.sample_valid = sv;
    bus.sample       = s;
    @(posedge clk);
    #1;
    reset            = 1'b0;
    bus.frame_start  = 1'b0;
    bus.sample_valid = 1'b0;
    if (r) begin
      m_bank = 0; m_active = 0; m_echo_v = 0; m_echo_a = 0; m_prev = 0; m_k = 0;
      exp_wr_en = 0; exp_p = 0; exp_n = 0; exp_busy = 0; exp_addr = 0; exp_data = 0;
    end else if (fs) begin
      m_bank = ~m_bank; m_active = 1; m_k = 0; m_prev = 0; m_echo_v = 0; m_echo_a = 0;
      exp_wr_en = 0; exp_p = 1; exp_n = 0; exp_busy = 1;
    end else if (sv && m_active) begin
      exp_wr_en = 1; exp_addr = m_k; exp_data = int'(s);
`ifdef SONAR_ECHO_DETECT_EN
      if (!m_echo_v && m_k >= HP * BH && m_k > BLANK && m_prev < TH && int'(s) >= TH) begin
        m_echo_v = 1; m_echo_a = m_k;
      end
`endif
      m_prev = int'(s);
      if (m_k == DEPTH - 1) begin
        m_active = 0; exp_busy = 0; exp_p = 0; exp_n = 0;
      end else begin
        exp_p = leg_p(m_k + 1);
        exp_n = (m_k + 1 < HP * BH) ? !exp_p : 1'b0;
      end
      m_k++;
    end else begin
      exp_wr_en = 0;
    end
    chk("wr_en", bus.wr_en, exp_wr_en);
    chk("busy", bus.busy, exp_busy);
    chk("pulse_p", bus.pulse_p, exp_p);
    chk("pulse_n", bus.pulse_n, exp_n);
    chk("legs_not_both_high", bus.pulse_p & bus.pulse_n, 0);
    chk("echo_valid", bus.echo_valid, m_echo_v);
    chk("echo_addr", bus.echo_addr, m_echo_a);
    if (exp_wr_en || r) begin
      chk("wr_addr", bus.wr_addr, exp_addr);
      chk("wr_data", bus.wr_data, exp_data);
      chk("wr_bank", bus.wr_bank, m_bank);
    end
  endtask

  function automatic logic [7:0] ramp(input int k);
    if (k >= 300 && k < 304) return 8'hC0;
    if (k >= 700 && k < 704) return 8'hD0;
    if (k >= 900 && k < 903) return 8'hF0;
    return 8'(k % 64);
  endfunction

  initial begin
    reset = 1'b1;
    bus.frame_start = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample = '0;

    // Reset wins over everything, including a coincident frame_start and strobe.
    step(1, 1, 1, 8'h55);
    step(1, 0, 0, 8'h00);

    // Idle with strobes: nothing is written.
    for (int i = 0; i < 100; i++) step(0, 0, 1'($urandom % 2), 8'($urandom));

    // Full frame of random samples at one strobe per four cycles, then strobes in DONE.
    step(0, 1, 0, 8'h00);
    for (int k = 0; k < DEPTH + 6; k++) begin
      step(0, 0, 1, 8'($urandom));
      repeat (3) step(0, 0, 0, 8'($urandom));
    end

    // Ramp frame crossing the threshold inside and outside the blanking zone.
    step(0, 1, 0, 8'h00);
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, 1, ramp(k));
      step(0, 0, 0, 8'($urandom));
    end
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);

    // Restart mid-burst with a coincident strobe, which must be dropped.
    for (int k = 0; k < 10; k++) step(0, 0, 1, 8'($urandom));
    step(0, 1, 1, 8'hAA);
    for (int k = 0; k < 40; k++) step(0, 0, 1, 8'($urandom));

    // Random mix of strobes, frame starts and occasional resets.
    for (int i = 0; i < 2000; i++)
      step(1'($urandom % 700 == 0), 1'($urandom % 300 == 0), 1'($urandom % 2), 8'($urandom));

    // Reset mid-frame together with frame_start.
    step(0, 1, 0, 8'h00);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 8'($urandom));
    step(1, 1, 1, 8'hFF);
    step(0, 0, 1, 8'h12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
